serial_link_arbiter: RTL and testbench



---
 rtl/serial_link_arbiter.sv | 167 ++++++++++++++++
 tb/tb_serial_link_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter and sequencer sharing one serial byte link between
// NUM_REQ requesters. Each transfer grants one requester, shifts its byte out
// LSB-first behind a one-cycle start strobe, then waits for the deserializer's
// done pulse (or a timeout) before pulsing ack (or err) back to the requester.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester request level, held until ack or err
//   req_data   byte for requester i at bits [8i+7:8i]
//   ack        one-cycle pulse, transfer for requester i completed
//   err        one-cycle pulse, transfer for requester i timed out
//   busy       high in every state except IDLE
//   grant_id   index of the current or last granted requester
//   link_start start strobe, coincident with bit 0
//   link_data  serial data bit
//   link_done  completion pulse from the deserializer
module serial_link_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       link_start,
  output logic                       link_data,
  input  logic                       link_done
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  state_t             state, state_d;
  logic [IDW-1:0]     ptr, ptr_d;
  logic [7:0]         shreg, shreg_d;
  logic [2:0]         bit_cnt, bit_cnt_d;
  logic [TOW-1:0]     to_cnt, to_cnt_d;
  logic [IDW-1:0]     grant_d;
  logic [NUM_REQ-1:0] ack_d, err_d;
  logic               busy_d, link_start_d, link_data_d;

  logic [7:0]         req_bytes [NUM_REQ];
  logic               found;
  logic [IDW-1:0]     win;
  int unsigned        idx;

  // Unpack the flat data bus into per-requester bytes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*8 +: 8];
    end
  end

  // Round-robin pick: first set request scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    shreg_d      = shreg;
    bit_cnt_d    = bit_cnt;
    to_cnt_d     = to_cnt;
    grant_d      = grant_id;
    ack_d        = '0;
    err_d        = '0;
    link_start_d = 1'b0;
    link_data_d  = 1'b0;

    case (state)
      S_IDLE: begin
        if (found) begin
          state_d      = S_SEND;
          grant_d      = win;
          ptr_d        = (32'(win) + 32'd1 >= NUM_REQ) ? '0 : IDW'(32'(win) + 32'd1);
          // Bit 0 goes straight onto the link; the register keeps the rest.
          link_data_d  = req_bytes[win][0];
          link_start_d = 1'b1;
          shreg_d      = {1'b0, req_bytes[win][7:1]};
          bit_cnt_d    = 3'd0;
        end
      end
      S_SEND: begin
        if (bit_cnt == 3'd7) begin
          state_d  = S_WAIT;
          to_cnt_d = '0;
        end else begin
          bit_cnt_d   = bit_cnt + 3'd1;
          link_data_d = shreg[0];
          shreg_d     = {1'b0, shreg[7:1]};
        end
      end
      S_WAIT: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (link_done) begin
          state_d         = S_ACK;
          ack_d[grant_id] = 1'b1;
        end else if (to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
          state_d         = S_ERR;
          err_d[grant_id] = 1'b1;
        end else begin
          to_cnt_d = to_cnt + TOW'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      grant_id   <= '0;
      ack        <= '0;
      err        <= '0;
      busy       <= 1'b0;
      link_start <= 1'b0;
      link_data  <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      shreg      <= shreg_d;
      bit_cnt    <= bit_cnt_d;
      to_cnt     <= to_cnt_d;
      grant_id   <= grant_d;
      ack        <= ack_d;
      err        <= err_d;
      busy       <= busy_d;
      link_start <= link_start_d;
      link_data  <= link_data_d;
    end
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Self-checking bench for serial_link_arbiter: directed scenarios followed by
// randomized transfers, compared against a transfer-level reference model
// (round-robin pick by modular scan, byte bits in LSB order, fixed latencies).
module tb_serial_link_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic           busy;
  logic [1:0]     grant_id;
  logic           link_start;
  logic           link_data;
  logic           link_done;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  serial_link_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .grant_id   (grant_id),
    .link_start (link_start),
    .link_data  (link_data),
    .link_done  (link_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first set request scanning from the pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant_id, 0);
    check({tag, "_start"}, link_start, 0);
    check({tag, "_data"}, link_data, 0);
  endtask

  // One complete transfer starting from an IDLE negedge.
  // done_at: WAIT cycle index at which link_done is pulsed, -1 = never.
  // abort_at: SEND bit index at which rst is asserted, -1 = no abort.
  task automatic transfer(input logic [N-1:0] reqv, input logic [31:0] bytes,
                          input int done_at, input bit stray, input bit drop_mid,
                          input int abort_at);
    int w;
    logic [7:0] b;
    check("idle_entry", busy, 0);
    req      = reqv;
    req_data = bytes;
    w        = pick(reqv, exp_ptr);
    exp_ptr  = (w + 1) % N;
    b        = bytes[w*8 +: 8];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("link_start", link_start, 32'(k == 0));
      check("link_data", link_data, b[k]);
      check("grant_id", grant_id, w);
      check("busy_send", busy, 1);
      check("ack_err_send", {ack, err}, 0);
      link_done = 1'b0;
      if (stray && k == 2) link_done = 1'b1;
      if (drop_mid && k == 3) req = '0;
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        link_done = 1'b0;
        exp_ptr = 0;
        check_all_zero("abort");
        return;
      end
    end
    link_done = 1'b0;
    @(negedge clk);
    check("wait_start", link_start, 0);
    check("wait_data", link_data, 0);
    check("wait_busy", busy, 1);
    for (int c = 0; c < TO; c++) begin
      check("wait_no_resp", {ack, err}, 0);
      link_done = (c == done_at);
      @(negedge clk);
      link_done = 1'b0;
      if (c == done_at) begin
        check("ack_pulse", ack, 32'(1 << w));
        check("ack_no_err", err, 0);
        break;
      end
      if (c == TO - 1) begin
        check("err_pulse", err, 32'(1 << w));
        check("err_no_ack", ack, 0);
      end
    end
    req = '0;
    check("resp_busy", busy, 1);
    check("resp_grant", grant_id, w);
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_ack_err", {ack, err}, 0);
    check("post_start", link_start, 0);
    check("post_grant", grant_id, w);
  endtask

  initial begin
    int r, d, ab;
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    link_done = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Round-robin contention: grants 0,1,2,3,0 with bytes 0x10+i.
    for (int i = 0; i < 5; i++) begin
      transfer(4'b1111, 32'h1312_1110, i + 1, 1'b0, 1'b0, -1);
    end

    // Single transfer, requester 1, 0xA5, done 3 cycles into WAIT.
    transfer(4'b0010, 32'h0000_A500, 3, 1'b0, 1'b0, -1);

    // Pointer order: grant 2, then 0101 serves 0 before 2.
    transfer(4'b0100, 32'h00C3_0000, 0, 1'b0, 1'b0, -1);
    transfer(4'b0101, 32'h0011_0022, 2, 1'b0, 1'b0, -1);
    transfer(4'b0100, 32'h0011_0000, 2, 1'b0, 1'b0, -1);

    // Timeout on requester 3, then requester 0 served with a stray done in SEND.
    transfer(4'b1000, 32'h5A00_0000, -1, 1'b0, 1'b0, -1);
    transfer(4'b0001, 32'h0000_0000, 1, 1'b1, 1'b0, -1);

    // Done coincident with the timeout cycle wins; requester drops req mid-transfer.
    transfer(4'b0010, 32'h0000_FF00, TO - 1, 1'b0, 1'b0, -1);
    transfer(4'b0100, 32'h0081_0000, 4, 1'b0, 1'b1, -1);

    // Reset at bit 4, then requester 2 restarts from a cleared pointer.
    transfer(4'b0100, 32'h0066_0000, 2, 1'b0, 1'b0, 4);
    transfer(4'b0100, 32'h0099_0000, 2, 1'b0, 1'b0, -1);

    // Randomized transfers.
    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 4));
      d  = (r == 0) ? -1 : int'($urandom_range(0, TO - 1));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      transfer(4'($urandom_range(1, 15)), $urandom, d,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
